cook_timer: RTL and testbench
=============================

Name: cook_timer

Overview:
- Countdown timer on the far side of the oven controller's `heat`/`finish` interface.
- The user loads a cook time in BCD mm:ss with button pulses.
- The timer counts down one second per prescaled tick while `heat` is high and freezes while `heat` is low.
- At 00:00 it returns a one-cycle `finish` pulse to the controller, which then rings the bell.

Parameters:
- TICKS_PER_SEC, default 1000: clk cycles per counted second; must be ≥ 2. Prescaler width is $clog2(TICKS_PER_SEC).

Ports:
- clk  in  1  system clock, all state on posedge.
- nrst  in  1  asynchronous active-low reset.
- heat  in  1  controller heating output; counting is enabled while high.
- add_min  in  1  one-cycle synchronous pulse: +1 minute.
- add_10s  in  1  one-cycle synchronous pulse: +10 seconds.
- clear  in  1  one-cycle synchronous pulse: zero the time.
- finish  out  1  registered, one-cycle pulse at end of cook; goes to the controller.
- running  out  1  high in RUN state.
- ready  out  1  high when the time is nonzero.
- min_tens, min_ones, sec_tens, sec_ones  out  4 each  BCD display digits (sec_tens 0..5).

Behaviour:
- Reset is asynchronous (nrst low). All digits are 0, prescaler is 0, finish=0, running=0, ready=0, state is IDLE. Asserting nrst mid-count aborts immediately with no finish pulse.
- States:
  - IDLE: time = 00:00.
  - SET: time nonzero, not counting.
  - RUN: counting.
  - HOLD: paused mid-count.
  - DONE: cook finished.
- Transitions:
  - IDLE → SET on an accepted add.
  - SET or HOLD → RUN when heat=1 and time ≠ 0.
  - RUN → HOLD when heat=0.
  - RUN → DONE when a tick decrements 00:01 to 00:00.
  - IDLE or SET → DONE when heat=1 and time = 00:00 (zero-time start).
  - DONE → IDLE when heat=0.
  - SET or HOLD → IDLE on clear.
- Editing:
  - Accepted only when heat=0 and state ≠ DONE.
  - Any add, clear, or clear+add input while heat=1 is ignored.
  - Same-cycle priority: clear > add_min > add_10s; the lower-priority pulse is dropped, not queued.
- add_min: minutes +1 in BCD (09→10). If the result exceeds 99:59, saturate to 99:59.
- add_10s: sec_tens +1. On 5→0, carry into minutes. Saturate to 99:59 on overflow; for example, 99:50 → 99:59.
- clear: time becomes 00:00 and prescaler becomes 0.
- Prescaler:
  - Increments only in RUN.
  - Wraps at TICKS_PER_SEC-1 → 0; that wrap cycle is the tick.
  - Keeps its value through HOLD, so pause and resume do not lose a partial second.
  - Resets to 0 on clear, on entry to DONE, and on reset.
- Decrement on tick, BCD with borrow:
  - sec_ones 0→9 borrows from sec_tens.
  - sec_tens 0→5 borrows from minutes.
  - min_ones 0→9 borrows from min_tens.
- finish:
  - Asserted for exactly one cycle, in the cycle after the state register enters DONE; the display already reads 00:00.
  - Never re-asserted while the block remains in DONE, even if heat stays high.
- running = (state == RUN).
- ready = (time ≠ 0), taken from the registered digits.
- Simultaneous tick and heat falling edge in the same cycle: the tick is consumed (decrement happens), then the block moves to HOLD.
- Digits never leave legal BCD ranges; no illegal value is reachable from reset.

Test Plan:
- Reset: assert nrst low at an arbitrary time → within the same cycle, all outputs are 0 and the digits read 00:00. Release, apply 10 idle cycles → outputs unchanged.
- Entry: 7× add_10s then 1× add_min → 02:10, ready=1. From 99:30, add_min → 99:59. From 99:50, add_10s → 99:59. clear+add_min in the same cycle → 00:00. add_min while heat=1 → ignored.
- Countdown (TICKS_PER_SEC=4): load 00:02, hold heat=1 →
  - 00:01 after 4 RUN cycles;
  - 00:00 after 8 RUN cycles;
  - finish=1 for exactly one cycle the cycle after that, then 0 while heat stays 1;
  - running=0;
  - heat→0 → IDLE.
- Pause (TICKS_PER_SEC=4): load 00:01, heat=1 for 2 cycles, heat=0 for 5 cycles (running=0, prescaler frozen), heat=1 again → 00:00 and finish after 2 more RUN cycles; the total RUN cycles equal 4.
- Borrow: load 10:00, run 1 tick → 09:59. Zero-time start: heat=1 at 00:00 → a single finish pulse on the next cycle.
- Abort: nrst low mid-run at 00:05 → immediate 00:00, no finish pulse ever follows.

Source files
------------

// File: rtl/cook_timer.sv
// cook_timer: BCD mm:ss cook countdown behind the oven controller's heat/finish link.
// Ports: clk, nrst (async low), heat, add_min/add_10s/clear pulses; finish, running, ready, BCD digits.
module cook_timer #(
  parameter int TICKS_PER_SEC = 1000
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic       heat,
  input  logic       add_min,
  input  logic       add_10s,
  input  logic       clear,
  output logic       finish,
  output logic       running,
  output logic       ready,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones
);

  localparam int PW = $clog2(TICKS_PER_SEC);
  localparam logic [PW-1:0] PMAX = PW'(TICKS_PER_SEC - 1);

  typedef enum logic [2:0] {
    IDLE, SET, RUN, HOLD, DONE
  } state_t;

  typedef struct packed {
    logic [3:0] mt;
    logic [3:0] mo;
    logic [3:0] st;
    logic [3:0] so;
  } tm_t;

  localparam tm_t MAXT = '{mt: 4'd9, mo: 4'd9, st: 4'd5, so: 4'd9};
  localparam tm_t ONE  = '{mt: 4'd0, mo: 4'd0, st: 4'd0, so: 4'd1};

  state_t        state;
  tm_t           t;
  tm_t           t_edit;
  tm_t           t_dec;
  logic [PW-1:0] pres;
  logic          done_q;
  logic          tick;
  logic          do_clr;
  logic          do_add;
  logic          sel_min;
  logic          sel_10s;

  function automatic tm_t inc_min(tm_t x);
    tm_t r;
    r = x;
    if (x.mt == 4'd9 && x.mo == 4'd9) begin
      r = MAXT;
    end else if (x.mo == 4'd9) begin
      r.mo = 4'd0;
      r.mt = x.mt + 4'd1;
    end else begin
      r.mo = x.mo + 4'd1;
    end
    return r;
  endfunction

  function automatic tm_t inc_10s(tm_t x);
    tm_t r;
    r = x;
    if (x.st == 4'd5) begin
      if (x.mt == 4'd9 && x.mo == 4'd9) begin
        r = MAXT;
      end else begin
        r = inc_min(x);
        r.st = 4'd0;
      end
    end else begin
      r.st = x.st + 4'd1;
    end
    return r;
  endfunction

  function automatic tm_t dec_one(tm_t x);
    tm_t r;
    r = x;
    if (x.so != 4'd0) begin
      r.so = x.so - 4'd1;
    end else begin
      r.so = 4'd9;
      if (x.st != 4'd0) begin
        r.st = x.st - 4'd1;
      end else begin
        r.st = 4'd5;
        if (x.mo != 4'd0) begin
          r.mo = x.mo - 4'd1;
        end else begin
          r.mo = 4'd9;
          r.mt = x.mt - 4'd1;
        end
      end
    end
    return r;
  endfunction

  // Edits are only honoured with heat low; the state case
  // below additionally restricts them to IDLE/SET/HOLD.
  assign do_clr  = clear & ~heat;
  assign do_add  = ~heat & ~clear & (add_min | add_10s);
  assign sel_min = add_min & ~clear;
  assign sel_10s = add_10s & ~add_min & ~clear;
  assign tick    = (state == RUN) && (pres == PMAX);
  assign t_dec   = dec_one(t);

  always_comb begin
    t_edit = t;
    unique case (1'b1)
      sel_min: t_edit = inc_min(t);
      sel_10s: t_edit = inc_10s(t);
      default: t_edit = t;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state  <= IDLE;
      t      <= '0;
      pres   <= '0;
      done_q <= 1'b0;
      finish <= 1'b0;
    end else begin
      // finish fires once, one cycle after DONE is entered
      done_q <= (state == DONE);
      finish <= (state == DONE) && !done_q;
      unique case (state)
        IDLE: begin
          if (heat) begin
            state <= DONE;
            pres  <= '0;
          end else if (do_add) begin
            state <= SET;
            t     <= t_edit;
          end
        end
        SET, HOLD: begin
          if (heat) begin
            state <= RUN;
          end else if (do_clr) begin
            state <= IDLE;
            t     <= '0;
            pres  <= '0;
          end else if (do_add) begin
            t <= t_edit;
          end
        end
        RUN: begin
          // a tick coinciding with heat falling still decrements
          pres <= tick ? '0 : pres + 1'b1;
          if (tick) t <= t_dec;
          if (tick && t == ONE) begin
            state <= DONE;
          end else if (!heat) begin
            state <= HOLD;
          end
        end
        DONE: begin
          pres <= '0;
          if (!heat) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign running  = (state == RUN);
  assign ready    = |t;
  assign min_tens = t.mt;
  assign min_ones = t.mo;
  assign sec_tens = t.st;
  assign sec_ones = t.so;

endmodule

// File: tb/tb_cook_timer.sv
// tb_cook_timer: directed + random stimulus for cook_timer.
// Reference model keeps time as total seconds and ticks as a cycle count.
module tb_cook_timer;
  localparam int TPS = 4;

  logic       clk = 1'b0;
  logic       nrst = 1'b0;
  logic       heat = 1'b0;
  logic       add_min = 1'b0;
  logic       add_10s = 1'b0;
  logic       clear = 1'b0;
  logic       finish;
  logic       running;
  logic       ready;
  logic [3:0] min_tens;
  logic [3:0] min_ones;
  logic [3:0] sec_tens;
  logic [3:0] sec_ones;

  int checks = 0;
  int errors = 0;

  int m_secs;
  int m_frac;
  bit m_run;
  bit m_done;
  bit m_fin;
  bit m_dprev;

  always #5 clk = ~clk;

  cook_timer #(.TICKS_PER_SEC(TPS)) dut (
    .clk      (clk),
    .nrst     (nrst),
    .heat     (heat),
    .add_min  (add_min),
    .add_10s  (add_10s),
    .clear    (clear),
    .finish   (finish),
    .running  (running),
    .ready    (ready),
    .min_tens (min_tens),
    .min_ones (min_ones),
    .sec_tens (sec_tens),
    .sec_ones (sec_ones)
  );

  function automatic logic [15:0] bcd(int s);
    int m;
    int x;
    m = s / 60;
    x = s % 60;
    return {4'(m / 10), 4'(m % 10), 4'(x / 10), 4'(x % 10)};
  endfunction

  function automatic logic [15:0] digits();
    return {min_tens, min_ones, sec_tens, sec_ones};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    m_secs  = 0;
    m_frac  = 0;
    m_run   = 1'b0;
    m_done  = 1'b0;
    m_fin   = 1'b0;
    m_dprev = 1'b0;
  endtask

  task automatic m_step(input bit h, input bit am, input bit a10,
                        input bit clr);
    bit fin_n;
    fin_n   = m_done && !m_dprev;
    m_dprev = m_done;
    if (m_done) begin
      if (!h) m_done = 1'b0;
    end else if (m_run) begin
      m_frac++;
      if (m_frac == TPS) begin
        m_frac = 0;
        m_secs--;
        if (m_secs == 0) begin
          m_run  = 1'b0;
          m_done = 1'b1;
        end
      end
      if (m_run && !h) m_run = 1'b0;
    end else if (h) begin
      if (m_secs == 0) begin
        m_done = 1'b1;
        m_frac = 0;
      end else begin
        m_run = 1'b1;
      end
    end else if (clr) begin
      m_secs = 0;
      m_frac = 0;
    end else if (am) begin
      m_secs = (m_secs + 60 > 5999) ? 5999 : m_secs + 60;
    end else if (a10) begin
      m_secs = (m_secs + 10 > 5999) ? 5999 : m_secs + 10;
    end
    m_fin = fin_n;
  endtask

  task automatic check_all(input string tag);
    chk({tag, "/digits"}, 32'(digits()), 32'(bcd(m_secs)));
    chk({tag, "/running"}, 32'(running), 32'(m_run));
    chk({tag, "/ready"}, 32'(ready), 32'(m_secs != 0));
    chk({tag, "/finish"}, 32'(finish), 32'(m_fin));
  endtask

  task automatic cyc(input bit h, input bit am, input bit a10,
                     input bit clr);
    heat    = h;
    add_min = am;
    add_10s = a10;
    clear   = clr;
    @(posedge clk);
    if (nrst) m_step(h, am, a10, clr);
    else m_reset();
    #1;
    check_all("cyc");
  endtask

  initial begin
    bit h;
    m_reset();
    #12;
    check_all("reset");
    chk("reset_digits", 32'(digits()), 32'h0);
    @(negedge clk);
    nrst = 1'b1;
    repeat (10) cyc(0, 0, 0, 0);
    chk("idle_digits", 32'(digits()), 32'h0);

    repeat (7) cyc(0, 0, 1, 0);
    cyc(0, 1, 0, 0);
    chk("entry_0210", 32'(digits()), 32'h0210);
    chk("entry_ready", 32'(ready), 32'h1);
    cyc(0, 0, 0, 1);

    repeat (99) cyc(0, 1, 0, 0);
    repeat (3) cyc(0, 0, 1, 0);
    chk("load_9930", 32'(digits()), 32'h9930);
    cyc(0, 1, 0, 0);
    chk("sat_min", 32'(digits()), 32'h9959);
    cyc(0, 0, 0, 1);
    repeat (99) cyc(0, 1, 0, 0);
    repeat (5) cyc(0, 0, 1, 0);
    chk("load_9950", 32'(digits()), 32'h9950);
    cyc(0, 0, 1, 0);
    chk("sat_10s", 32'(digits()), 32'h9959);
    cyc(0, 1, 0, 1);
    chk("clr_wins", 32'(digits()), 32'h0);

    cyc(0, 0, 1, 0);
    cyc(1, 1, 0, 0);
    chk("heat_ignores_add", 32'(digits()), 32'h0010);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 1);

    cyc(0, 0, 1, 0);
    repeat (32) cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 0);
    chk("tick_on_fall", 32'(digits()), 32'h0002);
    chk("tick_on_fall_run", 32'(running), 32'h0);
    cyc(1, 0, 0, 0);
    repeat (4) cyc(1, 0, 0, 0);
    chk("cd_0001", 32'(digits()), 32'h0001);
    repeat (4) cyc(1, 0, 0, 0);
    chk("cd_0000", 32'(digits()), 32'h0);
    chk("cd_nofin_yet", 32'(finish), 32'h0);
    cyc(1, 0, 0, 0);
    chk("cd_fin", 32'(finish), 32'h1);
    cyc(1, 0, 0, 0);
    chk("cd_fin_once", 32'(finish), 32'h0);
    chk("cd_not_running", 32'(running), 32'h0);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);

    cyc(0, 0, 1, 0);
    repeat (36) cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 0);
    chk("pause_0001", 32'(digits()), 32'h0001);
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 0);
    repeat (5) begin
      cyc(0, 0, 0, 0);
      chk("pause_frozen", 32'(running), 32'h0);
    end
    repeat (3) cyc(1, 0, 0, 0);
    chk("pause_done", 32'(digits()), 32'h0);
    cyc(1, 0, 0, 0);
    chk("pause_fin", 32'(finish), 32'h1);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);

    repeat (10) cyc(0, 1, 0, 0);
    repeat (5) cyc(1, 0, 0, 0);
    chk("borrow_0959", 32'(digits()), 32'h0959);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 1);

    cyc(1, 0, 0, 0);
    chk("zero_start_wait", 32'(finish), 32'h0);
    cyc(1, 0, 0, 0);
    chk("zero_start_fin", 32'(finish), 32'h1);
    cyc(1, 0, 0, 0);
    chk("zero_start_once", 32'(finish), 32'h0);
    cyc(0, 0, 0, 0);

    cyc(0, 0, 1, 0);
    repeat (21) cyc(1, 0, 0, 0);
    chk("abort_0005", 32'(digits()), 32'h0005);
    #2;
    nrst = 1'b0;
    #1;
    m_reset();
    check_all("abort");
    chk("abort_digits", 32'(digits()), 32'h0);
    repeat (3) cyc(0, 0, 0, 0);
    nrst = 1'b1;
    repeat (10) cyc(0, 0, 0, 0);

    h = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 19) == 0) h = !h;
      cyc(h, $urandom_range(0, 39) == 0, $urandom_range(0, 7) == 0,
          $urandom_range(0, 29) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
